// File: rtl/control_unit.sv
// control_unit -- hardwired Moore sequencer for the ezRISC datapath.
// Steps through fetch (T0-T2), decodes ir[31:27] and runs the execute steps
// (T3-T7). It drives every datapath control strobe from the registered state.
//
// Ports
//   clk, reset_n      clock and synchronous active-low reset
//   ir[31:0]          current instruction (op = ir[31:27])
//   con_ff            branch condition from the datapath CON flip-flop
//   stop              pause request, honoured only at an instruction boundary
//   gra..c_out        datapath strobes (register select, bus drives, loads, memory)
//   alu_op[3:0]       ALU function; holds Add outside ALU steps
//   run               1 while fetching or executing
//
// Parameter MEM_WAIT (0..15): extra cycles that read/write are held for memory.
// Optional build macro ILLEGAL_TRAP_EN: an illegal opcode halts the machine.
// When the macro is not defined, an illegal opcode executes as a nop.
module control_unit #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        gra, grb, grc,
  output logic        r_in, r_out, ba_out,
  output logic        hi_in, hi_out, lo_in, lo_out,
  output logic        pc_in, pc_out, inc_pc,
  output logic        ir_in, y_in, z_in, con_in,
  output logic        z_high_out, z_low_out,
  output logic        mar_in, mdr_in, mdr_out,
  output logic        read, write,
  output logic        inport_out, outport_in,
  output logic        c_out,
  output logic [3:0]  alu_op,
  output logic        run
);
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5,
    S_T6, S_T6W, S_T7, S_T7W, S_HALT, S_PAUSE
  } state_e;

  localparam logic [3:0] ADD  = 4'd2;
  localparam logic [3:0] WAIT = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [4:0] op;
  logic       unused_ir;
  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];

  logic is_alu, is_imm, is_md, is_nn, is_ld, is_ldi, is_st, is_br;
  logic is_jr, is_in, is_out, is_mfhi, is_mflo, is_nop, is_halt, is_one, is_ill;
  assign is_alu  = (op >= 5'd3) && (op <= 5'd10);
  assign is_imm  = (op >= 5'd11) && (op <= 5'd13);
  assign is_md   = (op == 5'd14) || (op == 5'd15);
  assign is_nn   = (op == 5'd16) || (op == 5'd17);
  assign is_ld   = (op == 5'd0);
  assign is_ldi  = (op == 5'd1);
  assign is_st   = (op == 5'd2);
  assign is_br   = (op == 5'd18);
  assign is_jr   = (op == 5'd19);
  assign is_in   = (op == 5'd21);
  assign is_out  = (op == 5'd22);
  assign is_mfhi = (op == 5'd23);
  assign is_mflo = (op == 5'd24);
  assign is_nop  = (op == 5'd25);
  assign is_halt = (op == 5'd26);
  assign is_one  = is_jr | is_in | is_out | is_mfhi | is_mflo;
  assign is_ill  = (op == 5'd20) || (op >= 5'd27);

  // ALU function for the opcode's ALU step
  logic [3:0] fn;
  always_comb begin
    fn = ADD;
    case (op)
      5'd4:         fn = 4'd3;
      5'd5, 5'd12:  fn = 4'd0;
      5'd6, 5'd13:  fn = 4'd1;
      5'd7:         fn = 4'd4;
      5'd8:         fn = 4'd5;
      5'd9:         fn = 4'd6;
      5'd10:        fn = 4'd7;
      5'd14:        fn = 4'd8;
      5'd15:        fn = 4'd9;
      5'd16:        fn = 4'd10;
      5'd17:        fn = 4'd11;
      default:      fn = ADD;
    endcase
  end

  // Last step of every instruction: stop diverts to PAUSE instead of T0.
  state_e end_st;
  logic   wait_done;
  assign end_st    = stop ? S_PAUSE : S_T0;
  assign wait_done = (cnt_q == WAIT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Wait counter: loaded with 1 on leaving a memory step into its W state,
  // so a W state lasts exactly MEM_WAIT cycles; zero everywhere else.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1: begin
        cnt_d   = 4'd1;
        state_d = (MEM_WAIT == 0) ? S_T2 : S_T1W;
      end
      S_T1W: begin
        if (wait_done) state_d = S_T2;
        else           cnt_d   = cnt_q + 4'd1;
      end
      S_T2: begin
        if (is_halt)     state_d = S_HALT;
        else if (is_nop) state_d = end_st;
        else if (is_ill)
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = end_st;
`endif
        else             state_d = S_T3;
      end
      S_T3: state_d = is_one ? end_st : S_T4;
      S_T4: state_d = (is_alu | is_imm | is_md | is_ld | is_ldi | is_st | is_br) ? S_T5 : end_st;
      S_T5: state_d = (is_ld | is_st | is_md | is_br) ? S_T6 : end_st;
      S_T6: begin
        if (is_ld) begin
          cnt_d   = 4'd1;
          state_d = (MEM_WAIT == 0) ? S_T7 : S_T6W;
        end else if (is_st) state_d = S_T7;
        else                state_d = end_st;
      end
      S_T6W: begin
        if (wait_done) state_d = S_T7;
        else           cnt_d   = cnt_q + 4'd1;
      end
      S_T7: begin
        if (is_st && MEM_WAIT != 0) begin
          cnt_d   = 4'd1;
          state_d = S_T7W;
        end else state_d = end_st;
      end
      S_T7W: begin
        if (wait_done) state_d = end_st;
        else           cnt_d   = cnt_q + 4'd1;
      end
      S_HALT:  state_d = S_HALT;
      S_PAUSE: state_d = stop ? S_PAUSE : S_T0;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    {gra, grb, grc, r_in, r_out, ba_out, hi_in, hi_out, lo_in, lo_out} = '0;
    {pc_in, pc_out, inc_pc, ir_in, y_in, z_in, con_in, z_high_out, z_low_out} = '0;
    {mar_in, mdr_in, mdr_out, read, write, inport_out, outport_in, c_out} = '0;
    alu_op = '0;
    run    = 1'b0;
    if (state_q != S_RESET && state_q != S_HALT && state_q != S_PAUSE) begin
      run    = 1'b1;
      alu_op = ADD;
    end
    case (state_q)
      S_T0:  begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
      S_T1:  begin z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
      S_T1W: begin read = 1'b1; mdr_in = 1'b1; end
      S_T2:  begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_T3: begin
        if (is_alu | is_imm)           begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
        if (is_nn)                     begin grb = 1'b1; r_out = 1'b1; alu_op = fn; z_in = 1'b1; end
        if (is_md)                     begin gra = 1'b1; r_out = 1'b1; y_in = 1'b1; end
        if (is_ld | is_ldi | is_st)    begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
        if (is_br)                     begin gra = 1'b1; r_out = 1'b1; con_in = 1'b1; end
        if (is_jr)                     begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
        if (is_in)                     begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        if (is_out)                    begin gra = 1'b1; r_out = 1'b1; outport_in = 1'b1; end
        if (is_mfhi)                   begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        if (is_mflo)                   begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
      end
      S_T4: begin
        if (is_alu)                    begin grc = 1'b1; r_out = 1'b1; alu_op = fn; z_in = 1'b1; end
        if (is_imm)                    begin c_out = 1'b1; alu_op = fn; z_in = 1'b1; end
        if (is_nn)                     begin z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        if (is_md)                     begin grb = 1'b1; r_out = 1'b1; alu_op = fn; z_in = 1'b1; end
        if (is_ld | is_ldi | is_st)    begin c_out = 1'b1; z_in = 1'b1; end
        if (is_br)                     begin pc_out = 1'b1; y_in = 1'b1; end
      end
      S_T5: begin
        if (is_alu | is_imm | is_ldi)  begin z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        if (is_md)                     begin z_low_out = 1'b1; lo_in = 1'b1; end
        if (is_ld | is_st)             begin z_low_out = 1'b1; mar_in = 1'b1; end
        if (is_br)                     begin c_out = 1'b1; z_in = 1'b1; end
      end
      S_T6: begin
        if (is_md)                     begin z_high_out = 1'b1; hi_in = 1'b1; end
        if (is_ld)                     begin read = 1'b1; mdr_in = 1'b1; end
        if (is_st)                     begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
        if (is_br)                     begin z_low_out = 1'b1; pc_in = con_ff; end
      end
      S_T6W: begin read = 1'b1; mdr_in = 1'b1; end
      S_T7: begin
        if (is_ld)                     begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        if (is_st)                     write = 1'b1;
      end
      S_T7W: write = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit. Two instances share the inputs:
// dut0 with MEM_WAIT=0 and dut2 with MEM_WAIT=2. All outputs of each are
// packed into one 32-bit word {run, alu_op, 27 strobes} and compared at the
// falling edge against hand-built expected words.
module tb_control_unit;
  logic        clk = 1'b0, reset_n = 1'b0, con_ff = 1'b0, stop = 1'b0;
  logic [31:0] ir = '0;
  wire  [31:0] cw0, cw2;
  int          errs = 0, checks = 0;

  always #5 clk = ~clk;

  localparam logic [26:0] GRA = 27'h1 << 26, GRB = 27'h1 << 25, GRC = 27'h1 << 24;
  localparam logic [26:0] R_IN = 27'h1 << 23, R_OUT = 27'h1 << 22, BA_OUT = 27'h1 << 21;
  localparam logic [26:0] HI_IN = 27'h1 << 20, HI_OUT = 27'h1 << 19, LO_IN = 27'h1 << 18;
  localparam logic [26:0] LO_OUT = 27'h1 << 17, PC_IN = 27'h1 << 16, PC_OUT = 27'h1 << 15;
  localparam logic [26:0] INC_PC = 27'h1 << 14, IR_IN = 27'h1 << 13, Y_IN = 27'h1 << 12;
  localparam logic [26:0] Z_IN = 27'h1 << 11, CON_IN = 27'h1 << 10, Z_HIGH = 27'h1 << 9;
  localparam logic [26:0] Z_LOW = 27'h1 << 8, MAR_IN = 27'h1 << 7, MDR_IN = 27'h1 << 6;
  localparam logic [26:0] MDR_OUT = 27'h1 << 5, READ = 27'h1 << 4, WRITE = 27'h1 << 3;
  localparam logic [26:0] C_OUT = 27'h1 << 0;
  localparam logic [3:0]  ADD = 4'd2, MUL = 4'd8;

  control_unit #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ir(ir), .con_ff(con_ff), .stop(stop),
    .run(cw0[31]), .alu_op(cw0[30:27]),
    .gra(cw0[26]), .grb(cw0[25]), .grc(cw0[24]), .r_in(cw0[23]), .r_out(cw0[22]),
    .ba_out(cw0[21]), .hi_in(cw0[20]), .hi_out(cw0[19]), .lo_in(cw0[18]), .lo_out(cw0[17]),
    .pc_in(cw0[16]), .pc_out(cw0[15]), .inc_pc(cw0[14]), .ir_in(cw0[13]), .y_in(cw0[12]),
    .z_in(cw0[11]), .con_in(cw0[10]), .z_high_out(cw0[9]), .z_low_out(cw0[8]),
    .mar_in(cw0[7]), .mdr_in(cw0[6]), .mdr_out(cw0[5]), .read(cw0[4]), .write(cw0[3]),
    .inport_out(cw0[2]), .outport_in(cw0[1]), .c_out(cw0[0])
  );

  control_unit #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .ir(ir), .con_ff(con_ff), .stop(stop),
    .run(cw2[31]), .alu_op(cw2[30:27]),
    .gra(cw2[26]), .grb(cw2[25]), .grc(cw2[24]), .r_in(cw2[23]), .r_out(cw2[22]),
    .ba_out(cw2[21]), .hi_in(cw2[20]), .hi_out(cw2[19]), .lo_in(cw2[18]), .lo_out(cw2[17]),
    .pc_in(cw2[16]), .pc_out(cw2[15]), .inc_pc(cw2[14]), .ir_in(cw2[13]), .y_in(cw2[12]),
    .z_in(cw2[11]), .con_in(cw2[10]), .z_high_out(cw2[9]), .z_low_out(cw2[8]),
    .mar_in(cw2[7]), .mdr_in(cw2[6]), .mdr_out(cw2[5]), .read(cw2[4]), .write(cw2[3]),
    .inport_out(cw2[2]), .outport_in(cw2[1]), .c_out(cw2[0])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check one running step, then advance to the next falling edge.
  task automatic s0(input string tag, input logic [3:0] alu, input logic [26:0] m);
    chk(tag, cw0, {1'b1, alu, m});
    @(negedge clk);
  endtask

  task automatic s2(input string tag, input logic [3:0] alu, input logic [26:0] m);
    chk(tag, cw2, {1'b1, alu, m});
    @(negedge clk);
  endtask

  task automatic idle0(input string tag);
    chk(tag, cw0, 32'h0);
    @(negedge clk);
  endtask

  // Reset both instances; returns at the falling edge of the first T0.
  task automatic rst();
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst0", cw0, 32'h0);
    chk("rst2", cw2, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic fetch0();
    s0("t0", ADD, PC_OUT | MAR_IN | INC_PC | Z_IN);
    s0("t1", ADD, Z_LOW | PC_IN | READ | MDR_IN);
    s0("t2", ADD, MDR_OUT | IR_IN);
  endtask

  initial begin
    // 1: addi R2,R1,-5
    ir = 32'h590F_FFFB;
    rst();
    fetch0();
    s0("addi_t3", ADD, GRB | R_OUT | Y_IN);
    s0("addi_t4", ADD, C_OUT | Z_IN);
    s0("addi_t5", ADD, Z_LOW | GRA | R_IN);
    chk("addi_t0_again", cw0, {1'b1, ADD, PC_OUT | MAR_IN | INC_PC | Z_IN});

    // 2: ld on the MEM_WAIT=2 instance, 12 steps then T0
    ir = 32'h0000_0000;
    rst();
    s2("ld_t0", ADD, PC_OUT | MAR_IN | INC_PC | Z_IN);
    s2("ld_t1", ADD, Z_LOW | PC_IN | READ | MDR_IN);
    s2("ld_t1w0", ADD, READ | MDR_IN);
    s2("ld_t1w1", ADD, READ | MDR_IN);
    s2("ld_t2", ADD, MDR_OUT | IR_IN);
    s2("ld_t3", ADD, GRB | BA_OUT | Y_IN);
    s2("ld_t4", ADD, C_OUT | Z_IN);
    s2("ld_t5", ADD, Z_LOW | MAR_IN);
    s2("ld_t6", ADD, READ | MDR_IN);
    s2("ld_t6w0", ADD, READ | MDR_IN);
    s2("ld_t6w1", ADD, READ | MDR_IN);
    s2("ld_t7", ADD, MDR_OUT | GRA | R_IN);
    chk("ld_t0_again", cw2, {1'b1, ADD, PC_OUT | MAR_IN | INC_PC | Z_IN});

    // 3: br, not taken then taken
    ir = 32'h9000_0000;
    rst();
    for (int t = 0; t < 2; t++) begin
      con_ff = (t == 1);
      fetch0();
      s0("br_t3", ADD, GRA | R_OUT | CON_IN);
      s0("br_t4", ADD, PC_OUT | Y_IN);
      s0("br_t5", ADD, C_OUT | Z_IN);
      s0(t == 1 ? "br_t6_taken" : "br_t6_not", ADD, t == 1 ? (Z_LOW | PC_IN) : Z_LOW);
    end
    con_ff = 1'b0;

    // 4: mul, stop raised in T4 takes effect only after T6
    ir = 32'h7000_0000;
    fetch0();
    s0("mul_t3", ADD, GRA | R_OUT | Y_IN);
    chk("mul_t4", cw0, {1'b1, MUL, GRB | R_OUT | Z_IN});
    stop = 1'b1;
    @(negedge clk);
    s0("mul_t5", ADD, Z_LOW | LO_IN);
    s0("mul_t6", ADD, Z_HIGH | HI_IN);
    idle0("mul_pause0");
    chk("mul_pause1", cw0, 32'h0);
    stop = 1'b0;
    @(negedge clk);
    s0("mul_resume_t0", ADD, PC_OUT | MAR_IN | INC_PC | Z_IN);

    // 5: reset during T4 of mul
    rst();
    fetch0();
    s0("mulr_t3", ADD, GRA | R_OUT | Y_IN);
    chk("mulr_t4", cw0, {1'b1, MUL, GRB | R_OUT | Z_IN});
    reset_n = 1'b0;
    @(negedge clk);
    chk("mulr_reset", cw0, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mulr_t0", cw0, {1'b1, ADD, PC_OUT | MAR_IN | INC_PC | Z_IN});

    // nop with stop raised before its end: pauses, then resumes
    ir = 32'hC800_0000;
    rst();
    s0("nop_t0", ADD, PC_OUT | MAR_IN | INC_PC | Z_IN);
    s0("nop_t1", ADD, Z_LOW | PC_IN | READ | MDR_IN);
    stop = 1'b1;
    s0("nop_t2", ADD, MDR_OUT | IR_IN);
    chk("nop_pause", cw0, 32'h0);
    stop = 1'b0;
    @(negedge clk);
    chk("nop_resume_t0", cw0, {1'b1, ADD, PC_OUT | MAR_IN | INC_PC | Z_IN});

    // 6: illegal opcode 10100
    ir = 32'hA000_0000;
    rst();
    fetch0();
`ifdef ILLEGAL_TRAP_EN
    idle0("ill_halt0");
    idle0("ill_halt1");
    chk("ill_halt2", cw0, 32'h0);
`else
    chk("ill_t0", cw0, {1'b1, ADD, PC_OUT | MAR_IN | INC_PC | Z_IN});
`endif

    // halt with stop also set: HALT wins and is sticky
    ir = 32'hD000_0000;
    rst();
    s0("halt_t0", ADD, PC_OUT | MAR_IN | INC_PC | Z_IN);
    s0("halt_t1", ADD, Z_LOW | PC_IN | READ | MDR_IN);
    stop = 1'b1;
    s0("halt_t2", ADD, MDR_OUT | IR_IN);
    stop = 1'b0;
    idle0("halt_0");
    idle0("halt_1");
    idle0("halt_2");
    rst();
    chk("halt_exit_t0", cw0, {1'b1, ADD, PC_OUT | MAR_IN | INC_PC | Z_IN});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
